prbs8_checker: RTL



---
 rtl/prbs8_pkg.sv | 19 +
 rtl/prbs8_popcount.sv | 14 +
 rtl/prbs8_checker.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/prbs8_pkg.sv
// Shared definitions for the 8-bit Fibonacci PRBS (x^8+x^6+x^5+x^4+1) checker:
// tap mask, checker state encoding, LFSR next-word function and the lock-up word.
package prbs8_pkg;

  // Feedback taps 8,6,5,4 map onto word bits 7,5,4,3.
  localparam logic [7:0] PRBS8_TAPS = 8'b1011_1000;
  localparam logic [7:0] PRBS8_ZERO = 8'h00;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } prbs8_state_e;

  // New bit enters at the top; the oldest bit falls off the bottom.
  function automatic logic [7:0] prbs8_step(input logic [7:0] w);
    return {^(w & PRBS8_TAPS), w[7:1]};
  endfunction

endpackage

// File: rtl/prbs8_popcount.sv
// Number of set bits in an 8-bit word; used for per-bit error accounting.
module prbs8_popcount (
  input  logic [7:0] word,
  output logic [3:0] count
);

  always_comb begin
    count = 4'd0;
    for (int k = 0; k < 8; k++) begin
      count = count + {3'b000, word[k]};
    end
  end

endmodule

// File: rtl/prbs8_checker.sv
// Self-synchronising checker for the 8-bit PRBS word stream with lock/loss
// hysteresis and saturating error counters. Optional PRBS8_CHECKER_BITERR_EN adds BIT_ERR_COUNT.
module prbs8_checker
  import prbs8_pkg::*;
#(
  parameter int unsigned SYNC_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [7:0]       I,
  input  logic             VALID,
  input  logic             CLEAR,
  output logic             LOCKED,
  output logic             ERR,
  output logic [CNT_W-1:0] ERR_COUNT,
  output logic             ZERO_STUCK
`ifdef PRBS8_CHECKER_BITERR_EN
  ,
  output logic [CNT_W-1:0] BIT_ERR_COUNT
`endif
);

  localparam logic [3:0] SYNC_C = 4'(SYNC_COUNT);
  localparam logic [3:0] LOSS_C = 4'(LOSS_COUNT);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [3:0]       b);
    logic [CNT_W+4:0] sum;
    sum = {5'b00000, a} + {{(CNT_W+1){1'b0}}, b};
    if (sum > {5'b00000, {CNT_W{1'b1}}}) begin
      return {CNT_W{1'b1}};
    end
    return sum[CNT_W-1:0];
  endfunction

  prbs8_state_e     state_q, state_d;
  logic [7:0]       prev_q, prev_d;
  logic [7:0]       exp_q, exp_d;
  logic             has_prev_q, has_prev_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [3:0]       miss_cnt_q, miss_cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             zero_q, zero_d;
  logic             hunt_match;
  logic             mismatch;

`ifdef PRBS8_CHECKER_BITERR_EN
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [3:0]       bit_diff;

  prbs8_popcount u_popcount (
    .word  (I ^ exp_q),
    .count (bit_diff)
  );
`endif

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    exp_d       = exp_q;
    has_prev_d  = has_prev_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    zero_d      = zero_q;
`ifdef PRBS8_CHECKER_BITERR_EN
    bit_cnt_d   = bit_cnt_q;
`endif
    hunt_match  = has_prev_q && (I == prbs8_step(prev_q)) && (I != PRBS8_ZERO);
    mismatch    = (I != exp_q);

    if (VALID) begin
      zero_d = (I == PRBS8_ZERO);
      case (state_q)
        ST_HUNT: begin
          prev_d     = I;
          has_prev_d = 1'b1;
          if (!hunt_match) begin
            match_cnt_d = 4'd0;
          end else if (match_cnt_q + 4'd1 == SYNC_C) begin
            state_d     = ST_LOCKED;
            exp_d       = prbs8_step(I);
            miss_cnt_d  = 4'd0;
            match_cnt_d = 4'd0;
          end else begin
            match_cnt_d = match_cnt_q + 4'd1;
          end
        end
        default: begin
          // The local sequence free-runs: a bad word never re-seeds it.
          exp_d = prbs8_step(exp_q);
`ifdef PRBS8_CHECKER_BITERR_EN
          bit_cnt_d = sat_add(bit_cnt_q, bit_diff);
`endif
          if (!mismatch) begin
            miss_cnt_d = 4'd0;
          end else begin
            err_d     = 1'b1;
            err_cnt_d = sat_add(err_cnt_q, 4'd1);
            if (miss_cnt_q + 4'd1 == LOSS_C) begin
              state_d     = ST_HUNT;
              prev_d      = I;
              has_prev_d  = 1'b1;
              match_cnt_d = 4'd0;
              miss_cnt_d  = 4'd0;
            end else begin
              miss_cnt_d = miss_cnt_q + 4'd1;
            end
          end
        end
      endcase
    end

    if (CLEAR) begin
      err_cnt_d = '0;
`ifdef PRBS8_CHECKER_BITERR_EN
      bit_cnt_d = '0;
`endif
    end
  end

  // Control and status registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_HUNT;
      has_prev_q  <= 1'b0;
      match_cnt_q <= 4'd0;
      miss_cnt_q  <= 4'd0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      zero_q      <= 1'b0;
`ifdef PRBS8_CHECKER_BITERR_EN
      bit_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      has_prev_q  <= has_prev_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      zero_q      <= zero_d;
`ifdef PRBS8_CHECKER_BITERR_EN
      bit_cnt_q   <= bit_cnt_d;
`endif
    end
  end

  // Data words: only consulted once has_prev / LOCKED qualify them.
  always_ff @(posedge CLK) begin
    prev_q <= prev_d;
    exp_q  <= exp_d;
  end

  assign LOCKED     = (state_q == ST_LOCKED);
  assign ERR        = err_q;
  assign ERR_COUNT  = err_cnt_q;
  assign ZERO_STUCK = zero_q;
`ifdef PRBS8_CHECKER_BITERR_EN
  assign BIT_ERR_COUNT = bit_cnt_q;
`endif

endmodule
